// File: rtl/jacaranda_pkg.sv
`default_nettype none
// ============================================================================
// Module      : jacaranda_pkg
// Description : Shared definitions for the jacaranda-8 computer.
//               Holds the program-loader state encoding, the wishbone byte
//               select and the instruction-memory base address.
// Contents    : ST_* state codes, state_e, SEL_BYTE0, IMEM_BASE_ADDR
// Revision    : 1.0 - initial release
// ============================================================================
package jacaranda_pkg;

  // Program-loader state codes
  localparam logic [1:0] ST_IDLE      = 2'd0;
  localparam logic [1:0] ST_WAIT_BYTE = 2'd1;
  localparam logic [1:0] ST_BUS       = 2'd2;
  localparam logic [1:0] ST_DONE      = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE      = ST_IDLE,
    S_WAIT_BYTE = ST_WAIT_BYTE,
    S_BUS       = ST_BUS,
    S_DONE      = ST_DONE
  } state_e;

  // One instruction byte sits in lane 0 of each 32-bit word slot
  localparam logic [3:0]  SEL_BYTE0      = 4'b0001;

  // Wishbone address of instruction-memory byte 0
  localparam logic [31:0] IMEM_BASE_ADDR = 32'h3000_0000;

endpackage
`default_nettype wire

// File: rtl/wb_prog_loader_if.sv
`default_nettype none
// ============================================================================
// Module      : wb_prog_loader_if
// Description : Single-beat wishbone write bundle between the program loader
//               (master) and the instruction-memory slave port.
// Signals     : wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o[3:0],
//               wbm_adr_o[31:0], wbm_dat_o[31:0] (master->slave),
//               wbm_ack_i (slave->master)
// Revision    : 1.0 - initial release
// ============================================================================
interface wb_prog_loader_if;
  logic        wbm_cyc_o;
  logic        wbm_stb_o;
  logic        wbm_we_o;
  logic [3:0]  wbm_sel_o;
  logic [31:0] wbm_adr_o;
  logic [31:0] wbm_dat_o;
  logic        wbm_ack_i;

  modport master (
    output wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o,
    input  wbm_ack_i
  );

  modport slave (
    input  wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o,
    output wbm_ack_i
  );
endinterface
`default_nettype wire

// File: rtl/wb_ack_timer.sv
`default_nettype none
// ============================================================================
// Module      : wb_ack_timer
// Description : Counts wishbone wait cycles; expired_o is high during the
//               TIMEOUT-th enabled cycle since the last clear.
// Ports       : clk_i, rst_ni (async active-low), clr_i, en_i, expired_o
// Revision    : 1.0 - initial release
// ============================================================================
module wb_ack_timer #(
  parameter int TIMEOUT = 255
) (
  input  wire logic clk_i,
  input  wire logic rst_ni,
  input  wire logic clr_i,
  input  wire logic en_i,
  output logic      expired_o
);

  localparam logic [15:0] c_LAST = 16'(TIMEOUT - 1);

  logic [15:0] cnt_q;

  // Counter holds once expired so it never wraps past the limit
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else if (clr_i) begin
      cnt_q <= '0;
    end else if (en_i && !expired_o) begin
      cnt_q <= cnt_q + 16'd1;
    end
  end

  assign expired_o = (cnt_q == c_LAST);

endmodule
`default_nettype wire

// File: rtl/wb_prog_loader.sv
`default_nettype none
// ============================================================================
// Module      : wb_prog_loader
// Description : Streams bytes from a valid/ready source into instruction
//               memory, one single-beat wishbone write per byte, while
//               holding the CPU in reset.
// Ports       : wb_clk_i, wb_rst_n (async active-low)
//               start_i, len_i[7:0] (0 = 256), abort_i
//               byte_valid_i, byte_data_i[7:0], byte_ready_o
//               wbm (wishbone master bundle)
//               busy_o, cpu_reset_o, done_o (pulse), error_o (sticky timeout)
// Revision    : 1.0 - initial release
// ============================================================================
module wb_prog_loader
  import jacaranda_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = IMEM_BASE_ADDR,
  parameter int          ADDR_STRIDE = 4,
  parameter int          TIMEOUT     = 255
) (
  input  wire logic         wb_clk_i,
  input  wire logic         wb_rst_n,
  input  wire logic         start_i,
  input  wire logic [7:0]   len_i,
  input  wire logic         abort_i,
  input  wire logic         byte_valid_i,
  input  wire logic [7:0]   byte_data_i,
  output logic              byte_ready_o,
  wb_prog_loader_if.master  wbm,
  output logic              busy_o,
  output logic              cpu_reset_o,
  output logic              done_o,
  output logic              error_o
);

  localparam logic [31:0] c_STRIDE = 32'(ADDR_STRIDE);

  state_e      state_q, state_d;
  logic [8:0]  rem_q, rem_d;
  logic [8:0]  idx_q, idx_d;
  logic [31:0] adr_q, adr_d;
  logic [31:0] dat_q, dat_d;
  logic        err_q, err_d;
  logic        cyc_q, cyc_d;
  logic [3:0]  sel_q, sel_d;
  logic        ready_q, ready_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        tmr_clr, tmr_en, tmr_expired;

  wb_ack_timer #(.TIMEOUT(TIMEOUT)) u_ack_timer (
    .clk_i     (wb_clk_i),
    .rst_ni    (wb_rst_n),
    .clr_i     (tmr_clr),
    .en_i      (tmr_en),
    .expired_o (tmr_expired)
  );

  always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      state_q <= S_IDLE;
      rem_q   <= '0;
      idx_q   <= '0;
      adr_q   <= '0;
      dat_q   <= '0;
      err_q   <= 1'b0;
      cyc_q   <= 1'b0;
      sel_q   <= '0;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      idx_q   <= idx_d;
      adr_q   <= adr_d;
      dat_q   <= dat_d;
      err_q   <= err_d;
      cyc_q   <= cyc_d;
      sel_q   <= sel_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    idx_d   = idx_q;
    adr_d   = adr_q;
    dat_d   = dat_q;
    err_d   = err_q;
    tmr_clr = 1'b0;
    tmr_en  = 1'b0;

    // Abort wins over everything, including an ack in the same cycle
    if (abort_i && (state_q != S_IDLE)) begin
      state_d = S_IDLE;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (start_i) begin
            rem_d   = (len_i == 8'd0) ? 9'd256 : {1'b0, len_i};
            idx_d   = '0;
            err_d   = 1'b0;
            state_d = S_WAIT_BYTE;
          end
        end
        S_WAIT_BYTE: begin
          if (byte_valid_i && ready_q) begin
            dat_d   = {24'd0, byte_data_i};
            adr_d   = BASE_ADDR + c_STRIDE * {23'd0, idx_q};
            tmr_clr = 1'b1;
            state_d = S_BUS;
          end
        end
        S_BUS: begin
          tmr_en = 1'b1;
          // Ack is checked first so a late ack on the expiry cycle succeeds
          if (wbm.wbm_ack_i) begin
            idx_d   = idx_q + 9'd1;
            rem_d   = rem_q - 9'd1;
            state_d = (rem_q == 9'd1) ? S_DONE : S_WAIT_BYTE;
          end else if (tmr_expired) begin
            err_d   = 1'b1;
            state_d = S_IDLE;
          end
        end
        S_DONE: begin
          state_d = S_IDLE;
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end

    // Outputs are registered copies of the next-state decode
    cyc_d   = (state_d == S_BUS);
    sel_d   = (state_d == S_BUS) ? SEL_BYTE0 : 4'b0000;
    ready_d = (state_d == S_WAIT_BYTE);
    busy_d  = (state_d != S_IDLE);
    done_d  = (state_d == S_DONE);
  end

  assign wbm.wbm_cyc_o = cyc_q;
  assign wbm.wbm_stb_o = cyc_q;
  assign wbm.wbm_we_o  = cyc_q;
  assign wbm.wbm_sel_o = sel_q;
  assign wbm.wbm_adr_o = adr_q;
  assign wbm.wbm_dat_o = dat_q;
  assign byte_ready_o  = ready_q;
  assign busy_o        = busy_q;
  assign cpu_reset_o   = busy_q;
  assign done_o        = done_q;
  assign error_o       = err_q;

endmodule
`default_nettype wire

// File: tb/tb_wb_prog_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_wb_prog_loader
// Description : Self-checking bench for wb_prog_loader. One instance uses the
//               default timeout, a second uses TIMEOUT=4 for the expiry case.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_wb_prog_loader;

  localparam logic [31:0] c_BASE = 32'h3000_0000;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start, abort, valid;
  logic [7:0] len, data;
  logic       ack;
  logic       start2, abort2, valid2, ack2;

  logic ready1, busy1, cpurst1, done1, err1;
  logic ready2, busy2, cpurst2, done2, err2;

  int n_checks = 0;
  int n_fail   = 0;
  int done_cnt = 0;
  int done2_cnt = 0;
  int wr_cnt   = 0;

  always #5 clk = ~clk;

  wb_prog_loader_if wb1 ();
  wb_prog_loader_if wb2 ();

  assign wb1.wbm_ack_i = ack;
  assign wb2.wbm_ack_i = ack2;

  wb_prog_loader u_dut (
    .wb_clk_i     (clk),
    .wb_rst_n     (rst_n),
    .start_i      (start),
    .len_i        (len),
    .abort_i      (abort),
    .byte_valid_i (valid),
    .byte_data_i  (data),
    .byte_ready_o (ready1),
    .wbm          (wb1),
    .busy_o       (busy1),
    .cpu_reset_o  (cpurst1),
    .done_o       (done1),
    .error_o      (err1)
  );

  wb_prog_loader #(.TIMEOUT(4)) u_dut_to (
    .wb_clk_i     (clk),
    .wb_rst_n     (rst_n),
    .start_i      (start2),
    .len_i        (len),
    .abort_i      (abort2),
    .byte_valid_i (valid2),
    .byte_data_i  (data),
    .byte_ready_o (ready2),
    .wbm          (wb2),
    .busy_o       (busy2),
    .cpu_reset_o  (cpurst2),
    .done_o       (done2),
    .error_o      (err2)
  );

  always @(posedge clk) begin
    if (done1) done_cnt++;
    if (done2) done2_cnt++;
    if (wb1.wbm_cyc_o && wb1.wbm_stb_o && ack) wr_cnt++;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Called at a negedge with the loader in WAIT_BYTE; returns at the negedge
  // after the ack edge.
  task automatic send_byte(input logic [7:0] d, input int delay,
                           input logic [31:0] ea, input logic [31:0] ed,
                           input logic last);
    chk("ready_before", 32'(ready1), 32'd1);
    valid = 1'b1;
    data  = d;
    @(negedge clk);
    valid = 1'b0;
    chk("cyc",   32'(wb1.wbm_cyc_o), 32'd1);
    chk("stb",   32'(wb1.wbm_stb_o), 32'd1);
    chk("we",    32'(wb1.wbm_we_o),  32'd1);
    chk("sel",   32'(wb1.wbm_sel_o), 32'h1);
    chk("adr",   wb1.wbm_adr_o, ea);
    chk("dat",   wb1.wbm_dat_o, ed);
    chk("ready_in_bus", 32'(ready1), 32'd0);
    for (int k = 0; k < delay; k++) begin
      @(negedge clk);
      chk("hold_stb", 32'(wb1.wbm_stb_o), 32'd1);
      chk("hold_adr", wb1.wbm_adr_o, ea);
      chk("hold_dat", wb1.wbm_dat_o, ed);
      chk("hold_ready", 32'(ready1), 32'd0);
    end
    ack = 1'b1;
    @(negedge clk);
    ack = 1'b0;
    chk("cyc_after_ack", 32'(wb1.wbm_cyc_o), 32'd0);
    chk("stb_after_ack", 32'(wb1.wbm_stb_o), 32'd0);
    if (last) begin
      chk("done_pulse", 32'(done1), 32'd1);
      chk("ready_at_done", 32'(ready1), 32'd0);
    end else begin
      chk("ready_after_ack", 32'(ready1), 32'd1);
      chk("no_done", 32'(done1), 32'd0);
    end
  endtask

  task automatic pulse_start(input logic [7:0] l);
    len   = l;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  typedef struct {
    logic [7:0]  data;
    int          delay;
    logic [31:0] exp_adr;
    logic [31:0] exp_dat;
  } vec_t;

  vec_t vecs[5];

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0, w0;
    // Load 1 (len 3): immediate acks. Load 2 (len 2): delayed acks.
    vecs[0] = '{8'hA1, 0, 32'h3000_0000, 32'h0000_00A1};
    vecs[1] = '{8'hB2, 0, 32'h3000_0004, 32'h0000_00B2};
    vecs[2] = '{8'hC3, 0, 32'h3000_0008, 32'h0000_00C3};
    vecs[3] = '{8'h5A, 5, 32'h3000_0000, 32'h0000_005A};
    vecs[4] = '{8'h3C, 2, 32'h3000_0004, 32'h0000_003C};

    rst_n = 1'b0; start = 0; abort = 0; valid = 0; len = 0; data = 0; ack = 0;
    start2 = 0; abort2 = 0; valid2 = 0; ack2 = 0;
    repeat (2) @(negedge clk);
    chk("rst_cyc",   32'(wb1.wbm_cyc_o), 32'd0);
    chk("rst_sel",   32'(wb1.wbm_sel_o), 32'd0);
    chk("rst_adr",   wb1.wbm_adr_o, 32'd0);
    chk("rst_dat",   wb1.wbm_dat_o, 32'd0);
    chk("rst_busy",  32'(busy1), 32'd0);
    chk("rst_ready", 32'(ready1), 32'd0);
    chk("rst_err",   32'(err1), 32'd0);
    chk("rst_done",  32'(done1), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Table-driven loads
    for (int ld = 0; ld < 2; ld++) begin
      int first = (ld == 0) ? 0 : 3;
      int cnt   = (ld == 0) ? 3 : 2;
      d0 = done_cnt; w0 = wr_cnt;
      pulse_start(8'(cnt));
      chk("busy_after_start",  32'(busy1), 32'd1);
      chk("cpurst_after_start", 32'(cpurst1), 32'd1);
      for (int i = first; i < first + cnt; i++)
        send_byte(vecs[i].data, vecs[i].delay, vecs[i].exp_adr, vecs[i].exp_dat,
                  i == first + cnt - 1);
      @(negedge clk);
      chk("done_low", 32'(done1), 32'd0);
      chk("busy_low", 32'(busy1), 32'd0);
      chk("cpurst_low", 32'(cpurst1), 32'd0);
      chk("done_count", 32'(done_cnt - d0), 32'd1);
      chk("write_count", 32'(wr_cnt - w0), 32'(cnt));
    end

    // Reset mid-BUS
    pulse_start(8'd1);
    valid = 1'b1; data = 8'h77;
    @(negedge clk);
    valid = 1'b0;
    chk("pre_rst_cyc", 32'(wb1.wbm_cyc_o), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("arst_cyc",   32'(wb1.wbm_cyc_o), 32'd0);
    chk("arst_stb",   32'(wb1.wbm_stb_o), 32'd0);
    chk("arst_busy",  32'(busy1), 32'd0);
    chk("arst_ready", 32'(ready1), 32'd0);
    chk("arst_adr",   wb1.wbm_adr_o, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // start_i while busy must not reload the count or index
    d0 = done_cnt;
    pulse_start(8'd2);
    send_byte(8'h11, 0, c_BASE, 32'h11, 1'b0);
    pulse_start(8'd5);
    chk("restart_ignored_ready", 32'(ready1), 32'd1);
    send_byte(8'h22, 0, c_BASE + 32'd4, 32'h22, 1'b1);
    @(negedge clk);
    chk("restart_busy_low", 32'(busy1), 32'd0);
    chk("restart_done_cnt", 32'(done_cnt - d0), 32'd1);

    // Abort together with ack on byte 2
    d0 = done_cnt;
    pulse_start(8'd3);
    send_byte(8'h01, 0, c_BASE, 32'h01, 1'b0);
    valid = 1'b1; data = 8'h02;
    @(negedge clk);
    valid = 1'b0;
    chk("abort_pre_cyc", 32'(wb1.wbm_cyc_o), 32'd1);
    ack = 1'b1; abort = 1'b1;
    @(negedge clk);
    ack = 1'b0; abort = 1'b0;
    chk("abort_cyc",   32'(wb1.wbm_cyc_o), 32'd0);
    chk("abort_busy",  32'(busy1), 32'd0);
    chk("abort_ready", 32'(ready1), 32'd0);
    chk("abort_err",   32'(err1), 32'd0);
    @(negedge clk);
    chk("abort_no_done", 32'(done_cnt - d0), 32'd0);

    // Full-length load
    d0 = done_cnt; w0 = wr_cnt;
    pulse_start(8'd0);
    for (int i = 0; i < 256; i++)
      send_byte(8'(i), 0, c_BASE + 32'(4 * i), 32'(i), i == 255);
    chk("full_last_adr", wb1.wbm_adr_o, 32'h3000_03FC);
    @(negedge clk);
    chk("full_busy_low", 32'(busy1), 32'd0);
    chk("full_done_cnt", 32'(done_cnt - d0), 32'd1);
    chk("full_writes",   32'(wr_cnt - w0), 32'd256);

    // Timeout on the TIMEOUT=4 instance
    len = 8'd1; start2 = 1'b1;
    @(negedge clk);
    start2 = 1'b0;
    chk("to_busy", 32'(busy2), 32'd1);
    valid2 = 1'b1; data = 8'h99;
    @(negedge clk);
    valid2 = 1'b0;
    chk("to_cyc_c1", 32'(wb2.wbm_cyc_o), 32'd1);
    for (int k = 2; k <= 4; k++) begin
      @(negedge clk);
      chk("to_cyc_hold", 32'(wb2.wbm_cyc_o), 32'd1);
      chk("to_err_early", 32'(err2), 32'd0);
    end
    @(negedge clk);
    chk("to_cyc_drop", 32'(wb2.wbm_cyc_o), 32'd0);
    chk("to_stb_drop", 32'(wb2.wbm_stb_o), 32'd0);
    chk("to_err_set",  32'(err2), 32'd1);
    chk("to_busy_low", 32'(busy2), 32'd0);
    repeat (3) @(negedge clk);
    chk("to_err_sticky", 32'(err2), 32'd1);
    chk("to_no_done", 32'(done2_cnt), 32'd0);
    start2 = 1'b1;
    @(negedge clk);
    start2 = 1'b0;
    chk("to_err_cleared", 32'(err2), 32'd0);
    chk("to_restart_busy", 32'(busy2), 32'd1);
    abort2 = 1'b1;
    @(negedge clk);
    abort2 = 1'b0;
    chk("to_abort_idle", 32'(busy2), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/wb_prog_loader.md
# wb_prog_loader

Wishbone initiator that streams a program image into the jacaranda-8 instruction memory through the wishbone slave port that the management side normally drives. It accepts bytes on a valid/ready stream, typically from a UART receiver, and issues one single-beat wishbone write per byte to consecutive instruction-memory addresses. It reports busy, done and error status, and holds the CPU in reset while loading.

## Interface
Parameters:
- `BASE_ADDR`, default 32'h3000_0000: wishbone address of instruction-memory byte 0.
- `ADDR_STRIDE`, default 4: address increment per byte, one byte per 32-bit word slot.
- `TIMEOUT`, default 255: maximum cycles to wait for `wbm_ack_i`; range 1..65535.

Ports:
- `wb_clk_i` in 1: the single clock.
- `wb_rst_n` in 1: asynchronous, active-low reset.
- `start_i` in 1: one-cycle pulse that begins a load; ignored while busy.
- `len_i` in 8: byte count, sampled on `start_i`; 0 means 256.
- `abort_i` in 1: synchronous abort.
- `byte_valid_i` in 1: stream byte valid.
- `byte_data_i` in 8: stream byte.
- `byte_ready_o` out 1: loader can accept a byte.
- `wbm_cyc_o` out 1: wishbone cycle.
- `wbm_stb_o` out 1: wishbone strobe.
- `wbm_we_o` out 1: write enable.
- `wbm_sel_o` out 4: byte select.
- `wbm_adr_o` out 32: address.
- `wbm_dat_o` out 32: write data.
- `wbm_ack_i` in 1: slave acknowledge.
- `busy_o` out 1: load in progress.
- `cpu_reset_o` out 1: drives the CPU reset (la_data_in[0] equivalent) during a load.
- `done_o` out 1: one-cycle pulse after the last ack.
- `error_o` out 1: sticky ack-timeout flag.

## Operation
- States: IDLE, WAIT_BYTE, BUS, DONE.
- IDLE:
  - `start_i` loads the remaining count from `len_i` (0→256), clears the index and `error_o`, and moves to WAIT_BYTE.
  - All other inputs are ignored.
- WAIT_BYTE:
  - `byte_ready_o`=1.
  - On `byte_valid_i & byte_ready_o`, latch `wbm_dat_o`={24'b0, byte_data_i} and `wbm_adr_o`=BASE_ADDR + ADDR_STRIDE×index (32-bit wrap), clear the timeout counter, then go to BUS.
- BUS:
  - `wbm_cyc_o`=`wbm_stb_o`=`wbm_we_o`=1, `wbm_sel_o`=4'b0001; all held stable until ack.
  - On `wbm_ack_i`: index+1 and remaining−1. If the remaining count reaches 0, go to DONE; otherwise go to WAIT_BYTE.
  - If no ack after TIMEOUT cycles in BUS: drop cyc/stb, set `error_o`, go to IDLE. No `done_o` is issued.
- DONE: `done_o`=1 for exactly one cycle, then IDLE.
- `busy_o`=`cpu_reset_o`=1 in WAIT_BYTE, BUS and DONE.
- `abort_i` in any non-IDLE state:
  - Go to IDLE on the next edge; cyc/stb drop that edge even mid-transfer.
  - `error_o` is not set and `done_o` is not pulsed.
  - `abort_i` takes priority over a same-cycle ack.
- Index is 9 bits wide, so a 256-byte load ends at index 256 with no wrap.
- Reset (asynchronous, any state): return to IDLE with all outputs 0, including `wbm_adr_o`, `wbm_dat_o`, `wbm_sel_o` and `error_o`.

## Timing
- All outputs are registered; no combinational path from any input to any output.
- Edge sequence per byte:
  - Byte accepted at edge N.
  - cyc/stb high from edge N+1.
  - Ack sampled at edge M ≥ N+1.
  - cyc/stb low and `byte_ready_o` high from edge M+1.
- Peak throughput is 1 byte per 2 cycles when the slave acks in the first BUS cycle.
- `start_i` to first `byte_ready_o`: 1 cycle.
- Last ack to `done_o`: 1 cycle. `done_o` to `busy_o` low: 1 cycle.
- Timeout fires on the edge ending the TIMEOUT-th BUS cycle without ack; cyc/stb low after that edge.
- An ack arriving in the same cycle as the timeout expiry counts as success.

## Structure
- Shared package `jacaranda_pkg`:
  - State encoding localparams.
  - Wishbone sel constant `SEL_BYTE0`=4'b0001.
  - Instruction-memory base address, also used by the computer top.
- One natural sub-module: `wb_ack_timer`, the timeout counter with clear/enable and an expired flag.
- Everything else stays in a single always block plus the output registers.

## Test plan
- Reset mid-BUS:
  - Stimulus: assert `wb_rst_n`=0 while cyc=1.
  - Required: cyc/stb/busy/ready drop immediately; `wbm_adr_o`=0.
- Basic load:
  - Stimulus: `len_i`=3; stream bytes 8'hA1, 8'hB2, 8'hC3; slave acks 1 cycle after stb.
  - Required: writes to 0x3000_0000, 0x3000_0004, 0x3000_0008 with data 0x0000_00A1, 0x0000_00B2, 0x0000_00C3, sel=0001; one `done_o` pulse; then `busy_o`=0.
- Back-pressure:
  - Stimulus: slave delays ack 5 cycles.
  - Required: adr/dat/stb stable throughout; `byte_ready_o`=0 until the cycle after ack.
- Timeout:
  - Stimulus: TIMEOUT=4, slave never acks.
  - Required: cyc drops after 4 BUS cycles; `error_o`=1 and stays set; no `done_o`; the next `start_i` clears `error_o`.
- Abort, and `start_i` while busy:
  - Stimulus: `abort_i` together with ack on byte 2.
  - Required: IDLE, no index increment, no `done_o`.
  - Stimulus: `start_i` during a load.
  - Required: count unchanged.
- Full length:
  - Stimulus: `len_i`=0.
  - Required: exactly 256 writes; last address 0x3000_03FC; `done_o` once.
